// File: rtl/turret_servo_pwm_if.sv
// APB slave bus used by the turret servo PWM block.
`timescale 1ns/1ps
interface turret_servo_pwm_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/turret_servo_pwm.sv
// Turret servo PWM generator: waits for a stable CCC lock, then produces a
// framed servo pulse whose width slews toward an APB-programmed target.
`timescale 1ns/1ps
module turret_servo_pwm #(
    parameter int unsigned CLK_DIV    = 100,
    parameter int unsigned PERIOD_US  = 20000,
    parameter int unsigned MIN_US     = 1000,
    parameter int unsigned MAX_US     = 2000,
    parameter int unsigned CENTER_US  = 1500,
    parameter int unsigned STEP_US    = 10,
    parameter int unsigned SETTLE_CYC = 1024
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              FAB_LOCK,
    turret_servo_pwm_if.slave apb,
    output logic              PWM_OUT,
    output logic              ACTIVE
);
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [15:0]   US_LAST     = 16'(PERIOD_US - 1);
    localparam logic [15:0]   MIN_W       = 16'(MIN_US);
    localparam logic [15:0]   MAX_W       = 16'(MAX_US);
    localparam logic [15:0]   CENTER_W    = 16'(CENTER_US);
    localparam logic [15:0]   STEP_W      = 16'(STEP_US);

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_TARGET  = 8'h04;
    localparam logic [7:0] ADDR_CURRENT = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h0C;

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t        state_q, state_d;
    logic          lock_meta_q, lock_q;
    logic [SW-1:0] settle_q, settle_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   us_q, us_d;
    logic          en_q, en_d;
    logic [15:0]   tgt_q, tgt_d;
    logic [15:0]   cur_q, cur_d;
    logic          pwm_q, pwm_d;

    logic          access, wr_en, mapped;
    logic [31:0]   rdata;
    logic [15:0]   wr_val, wr_clamped;
    logic          tick, wrap, frame_start;
    logic          step_up;
    logic [15:0]   diff, step_amt;

    // Two-flop synchroniser for the CCC lock level.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            lock_meta_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            lock_meta_q <= FAB_LOCK;
            lock_q      <= lock_meta_q;
        end
    end

    // Lock supervisor: any drop of the synced lock restarts the settle window.
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            WAIT_LOCK: if (lock_q) state_d = SETTLE;
            SETTLE: begin
                if (!lock_q)                    state_d = WAIT_LOCK;
                else if (settle_q == SETTLE_LAST) state_d = RUN;
                else                            settle_d = settle_q + 1'b1;
            end
            RUN:       if (!lock_q) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // APB decode; zero wait states, so the access phase is the whole transfer.
    always_comb begin
        access = apb.PSEL & apb.PENABLE;
        wr_en  = access & apb.PWRITE;
        mapped = (apb.PADDR == ADDR_CTRL) || (apb.PADDR == ADDR_TARGET) ||
                 (apb.PADDR == ADDR_CURRENT) || (apb.PADDR == ADDR_STATUS);
        rdata  = '0;
        case (apb.PADDR)
            ADDR_CTRL:    rdata = {31'd0, en_q};
            ADDR_TARGET:  rdata = {16'd0, tgt_q};
            ADDR_CURRENT: rdata = {16'd0, cur_q};
            ADDR_STATUS:  rdata = {30'd0, (cur_q == tgt_q), (state_q == RUN)};
            default:      rdata = '0;
        endcase
        apb.PREADY  = 1'b1;
        apb.PSLVERR = access & ~mapped;
        apb.PRDATA  = (access & ~apb.PWRITE) ? rdata : 32'd0;
    end

    // Frame timing, slew arithmetic and register write-back.
    always_comb begin
        tick        = (state_q == RUN) && (presc_q == PRESC_LAST);
        wrap        = tick && (us_q == US_LAST);
        // CURRENT only moves on the edge where us_cnt becomes 0.
        frame_start = ((state_q == SETTLE) && (state_d == RUN)) ||
                      ((state_q == RUN) && (state_d == RUN) && wrap);

        presc_d = '0;
        us_d    = '0;
        if ((state_q == RUN) && (state_d == RUN)) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            us_d    = tick ? (wrap ? 16'd0 : us_q + 16'd1) : us_q;
        end

        step_up  = tgt_q > cur_q;
        diff     = step_up ? (tgt_q - cur_q) : (cur_q - tgt_q);
        step_amt = (diff > STEP_W) ? STEP_W : diff;

        // The boundary uses the TARGET held before any same-edge write.
        cur_d = cur_q;
        if ((state_q == RUN) && (state_d == WAIT_LOCK))
            cur_d = CENTER_W;
        else if (frame_start && en_q)
            cur_d = step_up ? (cur_q + step_amt) : (cur_q - step_amt);

        wr_val     = apb.PWDATA[15:0];
        wr_clamped = (wr_val < MIN_W) ? MIN_W : ((wr_val > MAX_W) ? MAX_W : wr_val);
        en_d  = (wr_en && (apb.PADDR == ADDR_CTRL))   ? apb.PWDATA[0] : en_q;
        tgt_d = (wr_en && (apb.PADDR == ADDR_TARGET)) ? wr_clamped    : tgt_q;

        // Gated by the synced lock so a lock drop silences the pin one cycle later.
        pwm_d = (state_q == RUN) && lock_q && en_q && (us_q < cur_q);
    end

    // State, counters and programmable registers.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
            presc_q  <= '0;
            us_q     <= '0;
            en_q     <= 1'b0;
            tgt_q    <= CENTER_W;
            cur_q    <= CENTER_W;
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            presc_q  <= presc_d;
            us_q     <= us_d;
            en_q     <= en_d;
            tgt_q    <= tgt_d;
            cur_q    <= cur_d;
            pwm_q    <= pwm_d;
        end
    end

    assign PWM_OUT = pwm_q;
    assign ACTIVE  = (state_q == RUN);
endmodule
